rsa_decoder_8bit: RTL
=====================

RSA_DECODER_8BIT -- requirements
Module: rsa_decoder_8bit

Interface
REQ-001 SHALL have parameter W, default 8: width of cipher, key, modulus and plaintext.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request decryption; sampled only in IDLE.
REQ-005 SHALL have port cipher, input, W bits: ciphertext c, captured on accepted start.
REQ-006 SHALL have port d_key, input, W bits: private exponent d, captured on accepted start.
REQ-007 SHALL have port n_mod, input, W bits: modulus n, captured on accepted start.
REQ-008 SHALL have port plain, output, W bits: result m = c^d mod n; held until the next accepted start.
REQ-009 SHALL have port busy, output, 1 bit: high from the cycle after an accepted start until done.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when plain becomes valid.
REQ-011 SHALL have port err, output, 1 bit: set with done when n < 2; cleared on the next accepted start.

Function
REQ-012 SHALL implement FSM states IDLE, CHECK, REDUCE, MUL, SQR, SHIFT, FINISH.
REQ-013 SHALL accept start only in IDLE; start while busy is ignored, with no effect on the captured operands.
REQ-014 On accept, SHALL latch c, d and n, set result to 1 and go to CHECK.
REQ-015 In CHECK, if n < 2 SHALL go to FINISH with plain = 0 and err = 1; otherwise go to REDUCE.
REQ-016 In REDUCE, SHALL subtract n from base each cycle while base >= n; when base < n, SHALL go to SHIFT.
REQ-017 In SHIFT, if e == 0 SHALL go to FINISH; else if e[0] = 1 go to MUL; else go to SQR.
REQ-018 In MUL, SHALL compute result = result*base mod n using the sub-module, then go to SQR.
REQ-019 In SQR, SHALL compute base = base*base mod n, shift e right by one bit, then go to SHIFT.
REQ-020 In FINISH, SHALL drive plain = (result mod n), pulse done, drop busy and return to IDLE.
REQ-021 For d = 0, SHALL output plain = 1 (n >= 2).
REQ-022 The modmul sub-module SHALL use interleaved shift-add with reduction: r = 2r + b_i*a over W iterations, MSB first, with at most two conditional subtractions of n per iteration.
REQ-023 Intermediates SHALL be held W+2 bits wide.
REQ-024 The modmul sub-module SHALL assert its done exactly W+1 cycles after its go.
REQ-025 Total latency SHALL NOT exceed 3 + 2^(W-1) + 2W(W+2) cycles from start to done.
REQ-026 Total latency SHALL be deterministic for given operands.

Reset
REQ-027 rst SHALL force IDLE, with plain = 0, busy = 0, done = 0 and err = 0.
REQ-028 rst SHALL clear all internal registers, including the sub-module's.
REQ-029 rst mid-operation SHALL abort without a done pulse; the first start after rst is deasserted SHALL be accepted normally.

Structure
REQ-030 The FSM state encoding and the W default SHALL live in the shared package rsa_pkg.
REQ-031 The encoder SHALL reuse rsa_pkg.
REQ-032 The design SHALL contain exactly one sub-module, rsa_modmul_8bit, with ports clk, rst, go, a, b, n, r and done.
REQ-033 The top level SHALL time-share that single rsa_modmul_8bit instance between MUL and SQR.

Verification
REQ-034 c=31, d=7, n=33 -> single done pulse, plain = 4, err = 0.
REQ-035 c=8, d=27, n=55 -> plain = 2; c=200, d=1, n=33 -> plain = 2 (exercises REDUCE).
REQ-036 d=0, c=9, n=33 -> plain = 1; n=1 -> plain = 0, err = 1, done after 2 cycles.
REQ-037 Second start pulsed during busy -> ignored; plain is the result of the first operands only.
REQ-038 rst asserted mid-SQR -> no done; busy = 0 on the next cycle; a following run with c=31, d=7, n=33 gives plain = 4.
REQ-039 Round trip: encrypt m = 0..32 with e=3, n=33 in the bench, then decrypt with d=7 -> plain equals m for all values, and the latency bound holds.

Source files
------------

// File: rtl/rsa_decoder_8bit_pkg.sv
// -----------------------------------------------------------------------------
// rsa_pkg
//   Shared definitions for the RSA decoder slice.
//   - W_DEFAULT : default operand width (cipher, key, modulus, plaintext).
//   - state_t   : state encoding of the decoder FSM.
// -----------------------------------------------------------------------------
package rsa_pkg;

  localparam int W_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    REDUCE = 3'd2,
    MUL    = 3'd3,
    SQR    = 3'd4,
    SHIFT  = 3'd5,
    FINISH = 3'd6
  } state_t;

endpackage : rsa_pkg

// File: rtl/rsa_decoder_8bit_modmul.sv
// -----------------------------------------------------------------------------
// rsa_modmul_8bit
//   Sequential modular multiplier: r = (a * b) mod n, for a, b < n.
//   Interleaved shift-add, MSB of b first. Each iteration computes
//   acc = 2*acc + b_i*a and then subtracts n at most twice; since acc < n
//   and a < n, the sum stays below 3n, so two subtractions always suffice
//   and W+2 bits hold every intermediate.
//
//   Timing: go sampled on edge 0, W iteration edges follow, and done is
//   high for exactly one cycle, W+1 cycles after the cycle go was high.
//   r holds its value until the next go.
//
// Ports
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, clears every register
//   go   : start a multiplication (operands sampled with it)
//   a, b : multiplicands, W bits, both < n
//   n    : modulus, W bits
//   r    : product mod n, valid when done pulses
//   done : one-cycle completion pulse
// -----------------------------------------------------------------------------
module rsa_modmul_8bit
  import rsa_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic [W-1:0] r,
  output logic         done
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;      // shifted left each step; bit W-1 is the current bit
  logic [W+1:0]  n_q;
  logic [W+1:0]  acc_q;
  logic [CW-1:0] cnt_q;    // iterations still to run
  logic          run_q;
  logic          done_q;

  logic [W+1:0]  sum;
  logic [W+1:0]  sub1;
  logic [W+1:0]  sub2;

  // One iteration of the shift-add recurrence with its two reductions.
  always_comb begin
    sum  = (acc_q << 1) + (b_q[W-1] ? {2'b00, a} & '0 | {2'b00, a_q} : '0);
    sub1 = (sum  >= n_q) ? sum  - n_q : sum;
    sub2 = (sub1 >= n_q) ? sub1 - n_q : sub1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register reads the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset too, not just the control
      // flags, so a reset leaves no stale operand or partial product behind.
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (go) begin
        a_q   <= a;
        b_q   <= b;
        n_q   <= {2'b00, n};
        acc_q <= '0;
        cnt_q <= CW'(W);
        run_q <= 1'b1;
      end else if (run_q) begin
        acc_q <= sub2;
        b_q   <= b_q << 1;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign r    = acc_q[W-1:0];
  assign done = done_q;

endmodule : rsa_modmul_8bit

// File: rtl/rsa_decoder_8bit.sv
// -----------------------------------------------------------------------------
// rsa_decoder_8bit
//   RSA decryption m = c^d mod n by right-to-left square-and-multiply.
//   The base is first reduced below n by repeated subtraction, then the
//   exponent is consumed LSB first: a set bit multiplies the result by the
//   base, every bit squares the base. A single rsa_modmul_8bit instance is
//   shared between the multiply and the square steps.
//
//   Latency is a pure function of the operands: 1 CHECK cycle, one REDUCE
//   cycle per subtraction plus one, and per exponent bit one SHIFT cycle
//   plus W+1 cycles for each modmul issued, then FINISH.
//
// Ports
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   start  : request decryption, honoured only in IDLE
//   cipher : ciphertext c       (captured on accepted start)
//   d_key  : private exponent d (captured on accepted start)
//   n_mod  : modulus n          (captured on accepted start)
//   plain  : result, held until the next result is produced
//   busy   : high from the cycle after an accepted start until done
//   done   : one-cycle pulse when plain is valid
//   err    : modulus below 2; set with done, cleared on the next start
// -----------------------------------------------------------------------------
module rsa_decoder_8bit
  import rsa_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] cipher,
  input  logic [W-1:0] d_key,
  input  logic [W-1:0] n_mod,
  output logic [W-1:0] plain,
  output logic         busy,
  output logic         done,
  output logic         err
);

  state_t       state_q;
  state_t       state_d;

  logic [W-1:0] base_q;
  logic [W-1:0] e_q;
  logic [W-1:0] n_q;
  logic [W-1:0] result_q;
  logic [W-1:0] plain_q;
  logic         err_q;

  logic         mm_go;
  logic [W-1:0] mm_a;
  logic [W-1:0] mm_b;
  logic [W-1:0] mm_r;
  logic         mm_done;

  rsa_modmul_8bit #(
    .W (W)
  ) u_modmul (
    .clk  (clk),
    .rst  (rst),
    .go   (mm_go),
    .a    (mm_a),
    .b    (mm_b),
    .n    (n_q),
    .r    (mm_r),
    .done (mm_done)
  );

  // Next-state logic and modmul issue. A multiply is launched on the way
  // out of SHIFT; the square that follows a multiply is launched on the
  // cycle the multiply completes, so the shared unit never idles between
  // the two.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    mm_go   = 1'b0;
    mm_a    = base_q;
    mm_b    = base_q;

    unique case (state_q)
      IDLE: begin
        if (start) state_d = CHECK;
      end
      CHECK: begin
        state_d = (n_q < W'(2)) ? FINISH : REDUCE;
      end
      REDUCE: begin
        if (base_q < n_q) state_d = SHIFT;
      end
      SHIFT: begin
        if (e_q == '0) begin
          state_d = FINISH;
        end else begin
          mm_go = 1'b1;
          if (e_q[0]) begin
            mm_a    = result_q;
            state_d = MUL;
          end else begin
            state_d = SQR;
          end
        end
      end
      MUL: begin
        if (mm_done) begin
          mm_go   = 1'b1;
          state_d = SQR;
        end
      end
      SQR: begin
        if (mm_done) state_d = SHIFT;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register and datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      e_q      <= '0;
      n_q      <= '0;
      result_q <= '0;
      plain_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;

      unique case (state_q)
        IDLE: begin
          if (start) begin
            base_q   <= cipher;
            e_q      <= d_key;
            n_q      <= n_mod;
            result_q <= W'(1);
            err_q    <= 1'b0;
          end
        end
        CHECK: begin
          if (n_q < W'(2)) begin
            plain_q <= '0;
            err_q   <= 1'b1;
          end
        end
        REDUCE: begin
          if (base_q >= n_q) base_q <= base_q - n_q;
        end
        SHIFT: begin
          // plain is loaded on the edge into FINISH so it is already valid
          // during the done cycle. result is below n except for d = 0,
          // where it is still 1 < n; the reduction keeps plain in range
          // regardless.
          if (e_q == '0) begin
            plain_q <= (result_q >= n_q) ? result_q - n_q : result_q;
          end
        end
        MUL: begin
          if (mm_done) result_q <= mm_r;
        end
        SQR: begin
          if (mm_done) begin
            base_q <= mm_r;
            e_q    <= e_q >> 1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign plain = plain_q;
  assign err   = err_q;
  assign done  = (state_q == FINISH);
  assign busy  = (state_q != IDLE) && (state_q != FINISH);

endmodule : rsa_decoder_8bit
